// File: rtl/mips_mem_bus_pkg.sv
// Shared memory-space definitions for the MIPS memory bus: region bases,
// MMIO register offsets, the fault read-back word and the read-source select.
package mips_mem_bus_pkg;

   localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
   localparam logic [31:0] DATA_BASE = 32'h1001_0000;
   localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
   localparam int          MMIO_SPAN = 16;

   localparam logic [3:0] OFF_LED    = 4'h0;
   localparam logic [3:0] OFF_CYCLE  = 4'h4;
   localparam logic [3:0] OFF_CMP    = 4'h8;
   localparam logic [3:0] OFF_STATUS = 4'hC;

   localparam logic [31:0] BAD_WORD = 32'hDEAD_BEEF;

   // Which source drives mem_rd_data during the cycle after the address.
   typedef enum logic [2:0] {
      SEL_ZERO,
      SEL_TEXT,
      SEL_DATA,
      SEL_MMIO,
      SEL_ERR
   } rd_sel_e;

endpackage

// File: rtl/mips_sync_ram.sv
// Single-port synchronous RAM with registered read; a same-address
// read and write in one cycle returns the previous word.
module mips_sync_ram #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 32,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wr_data;
      end
      rd_data <= mem[addr];
   end

endmodule

// File: rtl/mips_mem_bus.sv
// MIPS memory bus: text/data RAM plus LED/timer MMIO with sticky fault capture.
// Define MIPS_MEM_BUS_TIMER_EN to build the cycle counter / compare / status timer.
module mips_mem_bus
   import mips_mem_bus_pkg::*;
#(
   parameter int TEXT_WORDS = 1024,
   parameter int DATA_WORDS = 1024,
   parameter int N          = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ena,
   input  logic [N-1:0] mem_addr,
   input  logic [N-1:0] mem_wr_data,
   input  logic         mem_wr_ena,
   output logic [N-1:0] mem_rd_data,
   output logic [31:0]  leds,
   output logic         timer_irq,
   output logic         bus_err,
   output logic [N-1:0] err_addr
);

   localparam int TEXT_AW = $clog2(TEXT_WORDS);
   localparam int DATA_AW = $clog2(DATA_WORDS);

   logic [N-1:0] text_off;
   logic [N-1:0] data_off;
   logic [N-1:0] mmio_off;
   logic         text_hit;
   logic         data_hit;
   logic         mmio_hit;
   logic         misaligned;
   logic         fault;
   logic         wr_commit;
   logic         mmio_wr;

   logic [N-1:0] text_rd;
   logic [N-1:0] data_rd;

   rd_sel_e      rd_sel_reg;
   rd_sel_e      rd_sel_next;
   logic [N-1:0] mmio_rd_reg;
   logic [N-1:0] mmio_rd_next;
   logic [31:0]  led_reg;
   logic         bus_err_reg;
   logic [N-1:0] err_addr_reg;

   logic [N-1:0] cycle_val;
   logic [N-1:0] cmp_val;
   logic         expired_val;

   // Offsets wrap below the base, so one unsigned compare bounds each region.
   assign text_off   = mem_addr - N'(TEXT_BASE);
   assign data_off   = mem_addr - N'(DATA_BASE);
   assign mmio_off   = mem_addr - N'(MMIO_BASE);
   assign text_hit   = text_off < N'(4 * TEXT_WORDS);
   assign data_hit   = data_off < N'(4 * DATA_WORDS);
   assign mmio_hit   = mmio_off < N'(MMIO_SPAN);
   assign misaligned = mem_addr[1:0] != 2'b00;
   assign fault      = misaligned | ~(text_hit | data_hit | mmio_hit);
   assign wr_commit  = mem_wr_ena & ena & ~fault & ~rst;
   assign mmio_wr    = wr_commit & mmio_hit;

   mips_sync_ram #(
      .DEPTH (TEXT_WORDS),
      .WIDTH (N)
   ) u_text_ram (
      .clk     (clk),
      .we      (wr_commit & text_hit),
      .addr    (text_off[TEXT_AW+1:2]),
      .wr_data (mem_wr_data),
      .rd_data (text_rd)
   );

   mips_sync_ram #(
      .DEPTH (DATA_WORDS),
      .WIDTH (N)
   ) u_data_ram (
      .clk     (clk),
      .we      (wr_commit & data_hit),
      .addr    (data_off[DATA_AW+1:2]),
      .wr_data (mem_wr_data),
      .rd_data (data_rd)
   );

`ifdef MIPS_MEM_BUS_TIMER_EN
   logic [N-1:0] cycle_reg;
   logic [N-1:0] cmp_reg;
   logic         expired_reg;
   logic         expire_hit;

   assign expire_hit = ena & (cycle_reg == cmp_reg) & (cmp_reg != '0);

   // A compare match in the same cycle as a write-1-clear keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_reg   <= '0;
         cmp_reg     <= '0;
         expired_reg <= 1'b0;
      end else begin
         if (ena) begin
            cycle_reg <= cycle_reg + 1'b1;
         end
         if (mmio_wr && mmio_off[3:0] == OFF_CMP) begin
            cmp_reg <= mem_wr_data;
         end
         if (expire_hit) begin
            expired_reg <= 1'b1;
         end else if (mmio_wr && mmio_off[3:0] == OFF_STATUS && mem_wr_data[0]) begin
            expired_reg <= 1'b0;
         end
      end
   end

   assign cycle_val   = cycle_reg;
   assign cmp_val     = cmp_reg;
   assign expired_val = expired_reg;
`else
   assign cycle_val   = '0;
   assign cmp_val     = '0;
   assign expired_val = 1'b0;
`endif

   always_comb begin
      rd_sel_next = SEL_MMIO;
      if (fault) begin
         rd_sel_next = SEL_ERR;
      end else if (text_hit) begin
         rd_sel_next = SEL_TEXT;
      end else if (data_hit) begin
         rd_sel_next = SEL_DATA;
      end

      mmio_rd_next = '0;
      case (mmio_off[3:0])
         OFF_LED:    mmio_rd_next = N'(led_reg);
         OFF_CYCLE:  mmio_rd_next = cycle_val;
         OFF_CMP:    mmio_rd_next = cmp_val;
         OFF_STATUS: mmio_rd_next = {{(N-1){1'b0}}, expired_val};
         default:    mmio_rd_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_sel_reg   <= SEL_ZERO;
         mmio_rd_reg  <= '0;
         led_reg      <= '0;
         bus_err_reg  <= 1'b0;
         err_addr_reg <= '0;
      end else begin
         rd_sel_reg  <= rd_sel_next;
         mmio_rd_reg <= mmio_rd_next;
         if (mmio_wr && mmio_off[3:0] == OFF_LED) begin
            led_reg <= mem_wr_data[31:0];
         end
         // Every cycle is a read, so an enabled faulting address always counts.
         if (fault && ena && !bus_err_reg) begin
            bus_err_reg  <= 1'b1;
            err_addr_reg <= mem_addr;
         end
      end
   end

   always_comb begin
      mem_rd_data = '0;
      case (rd_sel_reg)
         SEL_TEXT: mem_rd_data = text_rd;
         SEL_DATA: mem_rd_data = data_rd;
         SEL_MMIO: mem_rd_data = mmio_rd_reg;
         SEL_ERR:  mem_rd_data = N'(BAD_WORD);
         default:  mem_rd_data = '0;
      endcase
   end

   assign leds      = led_reg;
   assign timer_irq = expired_val;
   assign bus_err   = bus_err_reg;
   assign err_addr  = err_addr_reg;

endmodule

// File: tb/tb_mips_mem_bus.sv
// Self-checking bench for mips_mem_bus: directed steps plus random traffic
// checked against an address-keyed behavioural model of the memory map.
module tb_mips_mem_bus;

   localparam int TW = 1024;
   localparam int DW = 1024;
`ifdef MIPS_MEM_BUS_TIMER_EN
   localparam bit TIMER = 1'b1;
`else
   localparam bit TIMER = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ena = 1'b0;
   logic [31:0] mem_addr = 32'h0040_0000;
   logic [31:0] mem_wr_data = '0;
   logic        mem_wr_ena = 1'b0;
   logic [31:0] mem_rd_data;
   logic [31:0] leds;
   logic        timer_irq;
   logic        bus_err;
   logic [31:0] err_addr;

   always #5 clk = ~clk;

   mips_mem_bus #(
      .TEXT_WORDS (TW),
      .DATA_WORDS (DW),
      .N          (32)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .mem_addr    (mem_addr),
      .mem_wr_data (mem_wr_data),
      .mem_wr_ena  (mem_wr_ena),
      .mem_rd_data (mem_rd_data),
      .leds        (leds),
      .timer_irq   (timer_irq),
      .bus_err     (bus_err),
      .err_addr    (err_addr)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: RAM contents keyed by byte address, plus MMIO state.
   logic [31:0] m_mem [logic [31:0]];
   logic [31:0] m_led = '0, m_cnt = '0, m_cmp = '0, m_eaddr = '0;
   bit          m_exp = 1'b0, m_berr = 1'b0;

   logic [31:0] pool_ok [$];
   logic [31:0] pool_bad [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // 0 = fault, 1 = text, 2 = data, 3 = mmio
   function automatic int region(input logic [31:0] a);
      longint u;
      u = longint'(a);
      if (a[1:0] != 2'b00) return 0;
      if (u >= 64'h0040_0000 && u < 64'h0040_0000 + 4 * TW) return 1;
      if (u >= 64'h1001_0000 && u < 64'h1001_0000 + 4 * DW) return 2;
      if (u >= 64'hFFFF_0000 && u < 64'hFFFF_0010) return 3;
      return 0;
   endfunction

   task automatic step(input bit r, input bit e, input bit we,
                       input logic [31:0] a, input logic [31:0] d);
      int          kind;
      bit          known, set, clr;
      logic [31:0] exp_rd;
      rst = r; ena = e; mem_wr_ena = we; mem_addr = a; mem_wr_data = d;
      kind  = region(a);
      known = 1'b1;
      exp_rd = '0;
      if (!r) begin
         case (kind)
            0: exp_rd = 32'hDEAD_BEEF;
            1, 2: begin
               known = m_mem.exists(a);
               if (known) exp_rd = m_mem[a];
            end
            default: begin
               case (a[3:0])
                  4'h0: exp_rd = m_led;
                  4'h4: exp_rd = TIMER ? m_cnt : 32'h0;
                  4'h8: exp_rd = TIMER ? m_cmp : 32'h0;
                  default: exp_rd = {31'b0, m_exp};
               endcase
            end
         endcase
      end
      if (r) begin
         m_led = '0; m_cnt = '0; m_cmp = '0; m_exp = 1'b0; m_berr = 1'b0; m_eaddr = '0;
      end else begin
         set = TIMER && e && m_cnt == m_cmp && m_cmp != 0;
         clr = 1'b0;
         if (e && TIMER) m_cnt = m_cnt + 1;
         if (we && e && kind != 0) begin
            if (kind != 3) m_mem[a] = d;
            else if (a[3:0] == 4'h0) m_led = d;
            else if (a[3:0] == 4'h8 && TIMER) m_cmp = d;
            else if (a[3:0] == 4'hC) clr = d[0];
         end
         m_exp = set | (m_exp & ~clr);
         if (kind == 0 && e && !m_berr) begin
            m_berr = 1'b1;
            m_eaddr = a;
         end
      end
      @(posedge clk);
      #1;
      if (known) chk("rd_data", mem_rd_data, exp_rd);
      chk("leds", leds, m_led);
      chk("timer_irq", {31'b0, timer_irq}, {31'b0, m_exp});
      chk("bus_err", {31'b0, bus_err}, {31'b0, m_berr});
      chk("err_addr", err_addr, m_eaddr);
      $display("step rst=%0d ena=%0d we=%0d addr=%h wdata=%h -> rd=%h leds=%h irq=%0d err=%0d", r, e, we, a, d, mem_rd_data, leds, timer_irq, bus_err);
   endtask

   initial begin
      logic [31:0] a, d, v;
      int          sel;
      bit          e, w;

      for (int i = 0; i < 7; i++) begin
         pool_ok.push_back(32'h0040_0000 + 32'(4 * i));
         pool_ok.push_back(32'h1001_0000 + 32'(4 * i));
      end
      pool_ok.push_back(32'h0040_0000 + 32'(4 * (TW - 1)));
      pool_ok.push_back(32'h1001_0000 + 32'(4 * (DW - 1)));
      pool_bad = '{32'h0040_0000 + 32'(4 * TW), 32'h1001_0000 + 32'(4 * DW),
                   32'h2000_0000, 32'h1001_0002, 32'hFFFF_0010, 32'h003F_FFFC,
                   32'h0040_0001};

      // Reset state
      step(1, 0, 0, 32'h0040_0000, 0);
      step(1, 0, 0, 32'h0040_0000, 0);
      chk("reset_rd", mem_rd_data, 32'h0);

      // Compare = 10 right after reset
      step(0, 1, 1, 32'hFFFF_0008, 32'd10);

      // LED write blocked by ena=0, then accepted
      step(0, 0, 1, 32'hFFFF_0000, 32'h5A);
      chk("led_blocked", leds, 32'h0);
      step(0, 1, 1, 32'hFFFF_0000, 32'h5A);
      chk("led_written", leds, 32'h5A);

      // Data write then read-back
      step(0, 1, 1, 32'h1001_0004, 32'h1234_5678);
      step(0, 1, 0, 32'h1001_0004, 0);
      chk("data_rdback", mem_rd_data, 32'h1234_5678);

      // Read-before-write on text RAM
      step(0, 1, 1, 32'h0040_0000, 32'h1111_1111);
      step(0, 1, 1, 32'h0040_0000, 32'hAAAA_AAAA);
      chk("rbw_old", mem_rd_data, 32'h1111_1111);
      step(0, 1, 0, 32'h0040_0000, 0);
      chk("rbw_new", mem_rd_data, 32'hAAAA_AAAA);

      // Seed every pool word so later reads have known contents
      foreach (pool_ok[i]) step(0, 1, 1, pool_ok[i], $urandom);

      // Timer: wait for expiry, clear it, then a simultaneous set/clear
      for (int i = 0; i < 20 && !m_exp; i++) step(0, 1, 0, 32'hFFFF_0004, 0);
`ifdef MIPS_MEM_BUS_TIMER_EN
      chk("irq_expired", {31'b0, timer_irq}, 32'h1);
      step(0, 1, 1, 32'hFFFF_000C, 32'h1);
      chk("irq_cleared", {31'b0, timer_irq}, 32'h0);
      v = m_cnt + 1;
      step(0, 1, 1, 32'hFFFF_0008, v);
      step(0, 1, 1, 32'hFFFF_000C, 32'h1);
      chk("irq_set_wins", {31'b0, timer_irq}, 32'h1);
      step(0, 1, 1, 32'hFFFF_000C, 32'h1);
`else
      step(0, 1, 1, 32'hFFFF_000C, 32'h1);
      chk("irq_tied_low", {31'b0, timer_irq}, 32'h0);
`endif
      step(0, 1, 0, 32'hFFFF_000C, 0);

      // Fault capture keeps only the first address
      step(0, 1, 0, 32'h2000_0000, 0);
      chk("fault_word", mem_rd_data, 32'hDEAD_BEEF);
      step(0, 1, 0, 32'h1001_0002, 0);
      chk("err_addr_first", err_addr, 32'h2000_0000);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         sel = int'($urandom_range(0, 9));
         e   = $urandom_range(0, 3) != 0;
         w   = $urandom_range(0, 1) == 1;
         d   = $urandom;
         if (sel < 8) a = pool_ok[$urandom_range(0, pool_ok.size() - 1)];
         else if (sel < 9) a = 32'hFFFF_0000 + 32'(4 * $urandom_range(0, 3));
         else a = pool_bad[$urandom_range(0, pool_bad.size() - 1)];
         if (a == 32'hFFFF_0008) d = m_cnt + 32'($urandom_range(0, 3));
         step(0, e, w, a, d);
      end

      // Reset mid-run overrides a write and leaves RAM intact
      step(1, 1, 1, pool_ok[0], 32'h0BAD_0BAD);
      chk("rst_leds", leds, 32'h0);
      chk("rst_bus_err", {31'b0, bus_err}, 32'h0);
      foreach (pool_ok[i]) step(0, 1, 0, pool_ok[i], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
